truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Sequential exhaustive-stimulus and response checker for small combinational blocks, such as the 5-input single-output logic functions in this assignment set.
- Drives every input vector 0..2^N_IN-1 onto the DUT and samples the DUT's single output after a settle window.
- Assembles the captured truth table and compares it bit-for-bit against an expected table.
- Sits beside the DUT inside a self-checking top and replaces open-loop stimulus-only test fixtures.

Parameters:
- N_IN, 5, number of DUT inputs; vector width; 1..8 legal.
- SETTLE, 1, cycles the vector is held before sampling; minimum 1.
- EXPECTED, 32'h0000_0000, expected truth table; bit i = required y for vector i; width 2**N_IN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle.
- vec  out  N_IN  vector driven to DUT; MSB = first DUT input (a), LSB = last (e).
- y_in  in  1  DUT output.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse at end of sweep.
- pass  out  1  1 = captured table equals EXPECTED; valid from done until next accepted start.
- table_out  out  2**N_IN  captured truth table; bit i = sampled y for vector i.
- fail_count  out  N_IN+1  number of mismatching vectors.
- first_fail  out  N_IN  lowest mismatching vector index.
- first_fail_vld  out  1  high once any mismatch has been recorded in the current sweep.

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - state=IDLE; vec=0; busy=0; done=0; pass=0.
  - table_out=0; fail_count=0; first_fail=0; first_fail_vld=0.
  - settle counter=0.
- FSM states: IDLE, APPLY, SAMPLE, FINISH.
- IDLE:
  - On start=1: vec<=0, table_out<=0, fail_count<=0, first_fail_vld<=0, first_fail<=0, pass<=0, settle counter<=0, busy<=1, go to APPLY.
- APPLY:
  - vec is held stable.
  - The counter increments each cycle; when it reaches SETTLE-1, go to SAMPLE.
  - With SETTLE=1, APPLY lasts exactly 1 cycle.
- SAMPLE (one cycle):
  - table_out[vec]<=y_in.
  - If y_in != EXPECTED[vec]: fail_count<=fail_count+1.
  - If that mismatch occurs and first_fail_vld=0: first_fail<=vec, first_fail_vld<=1.
  - If vec == 2^N_IN-1: go to FINISH.
  - Otherwise: vec<=vec+1, counter<=0, go to APPLY.
- FINISH (one cycle):
  - done=1, busy<=0.
  - pass<=1 iff fail_count==0. fail_count already includes the last sample, because it was registered in the preceding SAMPLE.
  - Return to IDLE.
- After FINISH, vec remains at 2^N_IN-1 until the next start. table_out, fail_count, first_fail, first_fail_vld and pass hold their values.
- Latency: done is high in the cycle beginning (2^N_IN)*(SETTLE+1) clocks after the edge that accepted start. Default: 64.
- Boundary conditions:
  - vec does not wrap during a sweep; the end is detected by compare, not overflow.
  - fail_count width N_IN+1 holds the full 2^N_IN mismatches.
  - start while busy or during FINISH: ignored, no restart.
  - start in the same cycle as rst: rst wins.
  - rst mid-sweep: immediate return to reset values; no done pulse.
  - y_in equal to X/Z at sample counts as a mismatch: a case-inequality compare is used in simulation; synthesis is unaffected.

Decomposition:
- Shared header truth_table_defs.vh holds:
  - FSM state encodings: IDLE=2'd0, APPLY=2'd1, SAMPLE=2'd2, FINISH=2'd3.
  - Default N_IN and SETTLE localparams.
- One natural sub-module: tt_vector_sequencer.
  - Owns vec, the settle counter and the last-vector flag.
  - Issues a sample_en strobe to the capture/compare logic in the top.

Test Plan:
- DUT model y=vec[0], EXPECTED=32'hAAAA_AAAA, SETTLE=1, pulse start -> done exactly 64 cycles later; table_out=32'hAAAA_AAAA, pass=1, fail_count=0, first_fail_vld=0.
- Same DUT, EXPECTED=32'hAAAA_AAAB -> pass=0, fail_count=1, first_fail=0, first_fail_vld=1.
- DUT model y=~vec[0], EXPECTED=32'hAAAA_AAAA -> fail_count=32 (6'b100000), first_fail=0, table_out=32'h5555_5555.
- SETTLE=3, DUT model y=&vec, EXPECTED=32'h8000_0000 -> done 128 cycles after start; pass=1; each vec value is held 4 cycles.
- Assert rst at cycle 20 of a sweep -> all outputs return to reset values the next cycle; no done pulse; a fresh start then completes normally with pass=1.
- Pulse start at cycles 5 and 30 during a sweep and on the done cycle -> no restart; done occurs once at the original 64-cycle point; the next start after IDLE is accepted.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the exhaustive truth-table checker: FSM state
// encodings, default geometry and a width helper for the settle counter.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } tt_state_e;

  localparam int DEF_N_IN   = 5;
  localparam int DEF_SETTLE = 1;

  // Width of a counter that must reach settle-1; never narrower than one bit.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bundle of the checker's request/status signals and the DUT stimulus/response
// pair. The master side is the checker; the slave side is the surrounding
// self-checking top (start requester plus the block under test).
interface truth_table_checker_if #(
  parameter int N_IN = 5
);

  logic                 start;
  logic [N_IN-1:0]      vec;
  logic                 y_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2**N_IN-1:0]   table_out;
  logic [N_IN:0]        fail_count;
  logic [N_IN-1:0]      first_fail;
  logic                 first_fail_vld;

  modport master (
    input  start,
    input  y_in,
    output vec,
    output busy,
    output done,
    output pass,
    output table_out,
    output fail_count,
    output first_fail,
    output first_fail_vld
  );

  modport slave (
    output start,
    output y_in,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  table_out,
    input  fail_count,
    input  first_fail,
    input  first_fail_vld
  );

endinterface

// File: rtl/truth_table_checker_sequencer.sv
// Vector sequencer: walks vec through 0..2^N_IN-1, holds each value for SETTLE
// cycles, then raises sample_en for one cycle. Owns the sweep FSM, busy and
// the done pulse; capture/compare of the response lives in the top.
module tt_vector_sequencer
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            sweep_clear,
  output logic            sample_en,
  output logic            last_vec
);

  localparam int              CNT_W   = cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [N_IN-1:0]  VEC_MAX = '1;
  localparam logic [N_IN-1:0]  VEC_ONE = N_IN'(1);

  tt_state_e        state;
  logic [CNT_W-1:0] cnt;

  // A start is only honoured from IDLE; the top uses this to clear its results
  // on the same edge that launches the sweep.
  assign sweep_clear = (state == IDLE) && start;
  assign sample_en   = (state == SAMPLE);
  // End of sweep is found by comparing against the top vector, so vec never wraps.
  assign last_vec    = (vec == VEC_MAX);

  // Sweep FSM with vector register, settle counter, busy and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= APPLY;
          end
        end
        APPLY: begin
          if (cnt == CNT_END) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SAMPLE: begin
          if (last_vec) begin
            // done is registered here so it is high during the FINISH cycle.
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            vec   <= vec + VEC_ONE;
            cnt   <= '0;
            state <= APPLY;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: sweeps every input vector of a small
// single-output combinational block, captures its response table and compares
// it bit-for-bit against EXPECTED, reporting count and first failing vector.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                 N_IN     = DEF_N_IN,
  parameter int                 SETTLE   = DEF_SETTLE,
  parameter logic [2**N_IN-1:0] EXPECTED = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_checker_if.master bus
);

  localparam logic [N_IN:0] FC_ONE = (N_IN + 1)'(1);

  logic sweep_clear;
  logic sample_en;
  logic last_vec;
  logic exp_bit;
  logic mismatch;

  tt_vector_sequencer #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .start       (bus.start),
    .vec         (bus.vec),
    .busy        (bus.busy),
    .done        (bus.done),
    .sweep_clear (sweep_clear),
    .sample_en   (sample_en),
    .last_vec    (last_vec)
  );

  assign exp_bit  = EXPECTED[bus.vec];
  // Case inequality makes an X/Z response count as a mismatch in simulation;
  // synthesis treats it as an ordinary inequality.
  assign mismatch = (bus.y_in !== exp_bit);

  // Result capture: clear on an accepted start, record one table bit per sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.table_out      <= '0;
      bus.fail_count     <= '0;
      bus.first_fail     <= '0;
      bus.first_fail_vld <= 1'b0;
      bus.pass           <= 1'b0;
    end else if (sweep_clear) begin
      bus.table_out      <= '0;
      bus.fail_count     <= '0;
      bus.first_fail     <= '0;
      bus.first_fail_vld <= 1'b0;
      bus.pass           <= 1'b0;
    end else if (sample_en) begin
      bus.table_out[bus.vec] <= bus.y_in;
      if (mismatch) begin
        bus.fail_count <= bus.fail_count + FC_ONE;
        if (!bus.first_fail_vld) begin
          bus.first_fail     <= bus.vec;
          bus.first_fail_vld <= 1'b1;
        end
      end
      // Verdict folds in the final sample so pass is already valid while done
      // is high; it then holds until the next accepted start.
      if (last_vec) begin
        bus.pass <= (bus.fail_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: three checker instances with
// different EXPECTED/SETTLE values, each next to a tiny behavioural DUT.
module tb_truth_table_checker;
  import truth_table_checker_pkg::*;

  localparam int LIMIT = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inv_a = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int dcnt_a = 0;
  int dcnt_b = 0;
  int dcnt_c = 0;

  always #5 clk = ~clk;

  truth_table_checker_if #(.N_IN(5)) ifa ();
  truth_table_checker_if #(.N_IN(5)) ifb ();
  truth_table_checker_if #(.N_IN(5)) ifc ();

  // Behavioural blocks under test.
  assign ifa.y_in = inv_a ? ~ifa.vec[0] : ifa.vec[0];
  assign ifb.y_in = ifb.vec[0];
  assign ifc.y_in = &ifc.vec;

  truth_table_checker #(.N_IN(5), .SETTLE(1), .EXPECTED(32'hAAAA_AAAA)) u_a (
    .clk (clk), .rst (rst), .bus (ifa));
  truth_table_checker #(.N_IN(5), .SETTLE(1), .EXPECTED(32'hAAAA_AAAB)) u_b (
    .clk (clk), .rst (rst), .bus (ifb));
  truth_table_checker #(.N_IN(5), .SETTLE(3), .EXPECTED(32'h8000_0000)) u_c (
    .clk (clk), .rst (rst), .bus (ifc));

  // Count done pulses per instance.
  always @(posedge clk) begin
    if (ifa.done) dcnt_a <= dcnt_a + 1;
    if (ifb.done) dcnt_b <= dcnt_b + 1;
    if (ifc.done) dcnt_c <= dcnt_c + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      0: ifa.start = v;
      1: ifb.start = v;
      default: ifc.start = v;
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      0: return ifa.done;
      1: return ifb.done;
      default: return ifc.done;
    endcase
  endfunction

  function automatic logic [4:0] get_vec(input int w);
    case (w)
      0: return ifa.vec;
      1: return ifb.vec;
      default: return ifc.vec;
    endcase
  endfunction

  // Launch a sweep on instance w; lat = edges from the accepting edge to the
  // first cycle with done high (-1 if never). bad counts cycles where vec
  // differs from the expected hold pattern. glitch adds extra start pulses
  // sampled at edges 5, 30 and the edge right after done.
  task automatic sweep(input int w, input int settle, input bit glitch,
                       output int lat, output int bad);
    int ev;
    lat = -1;
    bad = 0;
    @(negedge clk);
    set_start(w, 1'b1);
    @(posedge clk);
    #1;
    set_start(w, 1'b0);
    for (int j = 1; j <= LIMIT; j++) begin
      @(posedge clk);
      #1;
      ev = j / (settle + 1);
      if (ev > 31) ev = 31;
      if (get_vec(w) != 5'(ev)) bad++;
      if (get_done(w) && lat < 0) lat = j;
      if (glitch) set_start(w, (j == 4) || (j == 29) || (j == 64));
      if (lat >= 0 && (!glitch || j > lat)) break;
    end
    set_start(w, 1'b0);
  endtask

  int lat;
  int bad;
  int d0;

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec",   64'(ifa.vec), 64'd0);
    check("rst_busy",  64'(ifa.busy), 64'd0);
    check("rst_done",  64'(ifa.done), 64'd0);
    check("rst_pass",  64'(ifa.pass), 64'd0);
    check("rst_table", 64'(ifa.table_out), 64'd0);
    check("rst_fc",    64'(ifa.fail_count), 64'd0);
    check("rst_ffv",   64'(ifa.first_fail_vld), 64'd0);
    check("rst_ff",    64'(ifa.first_fail), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // y = vec[0] against matching table.
    sweep(0, 1, 1'b0, lat, bad);
    check("t1_lat",   64'(lat), 64'd64);
    check("t1_hold",  64'(bad), 64'd0);
    check("t1_busy",  64'(ifa.busy), 64'd1);
    check("t1_table", 64'(ifa.table_out), 64'hAAAA_AAAA);
    check("t1_pass",  64'(ifa.pass), 64'd1);
    check("t1_fc",    64'(ifa.fail_count), 64'd0);
    check("t1_ffv",   64'(ifa.first_fail_vld), 64'd0);
    @(posedge clk);
    #1;
    check("t1_done_pulse", 64'(ifa.done), 64'd0);
    check("t1_busy_off",   64'(ifa.busy), 64'd0);
    check("t1_vec_end",    64'(ifa.vec), 64'd31);
    check("t1_pass_hold",  64'(ifa.pass), 64'd1);

    // Same response, EXPECTED differs only at vector 0.
    sweep(1, 1, 1'b0, lat, bad);
    check("t2_lat",  64'(lat), 64'd64);
    check("t2_pass", 64'(ifb.pass), 64'd0);
    check("t2_fc",   64'(ifb.fail_count), 64'd1);
    check("t2_ff",   64'(ifb.first_fail), 64'd0);
    check("t2_ffv",  64'(ifb.first_fail_vld), 64'd1);

    // Inverted response: every vector mismatches.
    inv_a = 1'b1;
    sweep(0, 1, 1'b0, lat, bad);
    check("t3_lat",   64'(lat), 64'd64);
    check("t3_fc",    64'(ifa.fail_count), 64'd32);
    check("t3_ff",    64'(ifa.first_fail), 64'd0);
    check("t3_ffv",   64'(ifa.first_fail_vld), 64'd1);
    check("t3_table", 64'(ifa.table_out), 64'h5555_5555);
    check("t3_pass",  64'(ifa.pass), 64'd0);
    inv_a = 1'b0;

    // SETTLE=3 with a 5-input AND.
    sweep(2, 3, 1'b0, lat, bad);
    check("t4_lat",   64'(lat), 64'd128);
    check("t4_hold",  64'(bad), 64'd0);
    check("t4_pass",  64'(ifc.pass), 64'd1);
    check("t4_table", 64'(ifc.table_out), 64'h8000_0000);
    check("t4_fc",    64'(ifc.fail_count), 64'd0);

    // Reset in the middle of a sweep, with start asserted alongside it.
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("t5_midsweep_busy", 64'(ifa.busy), 64'd1);
    rst = 1'b1;
    ifa.start = 1'b1;
    @(posedge clk);
    #1;
    check("t5_vec",   64'(ifa.vec), 64'd0);
    check("t5_busy",  64'(ifa.busy), 64'd0);
    check("t5_done",  64'(ifa.done), 64'd0);
    check("t5_table", 64'(ifa.table_out), 64'd0);
    check("t5_fc",    64'(ifa.fail_count), 64'd0);
    check("t5_pass",  64'(ifa.pass), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ifa.start = 1'b0;
    d0 = dcnt_a;
    repeat (80) @(posedge clk);
    #1;
    check("t5_no_done",  64'(dcnt_a - d0), 64'd0);
    check("t5_idle",     64'(ifa.busy), 64'd0);
    sweep(0, 1, 1'b0, lat, bad);
    check("t5_lat",  64'(lat), 64'd64);
    check("t5_pass", 64'(ifa.pass), 64'd1);

    // Extra start pulses while busy and on the done cycle are ignored.
    repeat (2) @(posedge clk);
    d0 = dcnt_a;
    sweep(0, 1, 1'b1, lat, bad);
    check("t6_lat",  64'(lat), 64'd64);
    check("t6_hold", 64'(bad), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("t6_one_done", 64'(dcnt_a - d0), 64'd1);
    check("t6_busy",     64'(ifa.busy), 64'd0);
    check("t6_vec",      64'(ifa.vec), 64'd31);
    sweep(0, 1, 1'b0, lat, bad);
    check("t6_restart_lat",  64'(lat), 64'd64);
    check("t6_restart_pass", 64'(ifa.pass), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
